onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter in front of a single-port on-chip RAM (altsyncram, SINGLE_PORT, 32-bit, 13-bit word address, byte enables, unregistered q, so read latency is 1).
- Presents two Avalon-MM slave ports, m0 and m1, each with waitrequest and readdatavalid, to independent masters, e.g. the CPU data master and a DMA.
- Drives one memory-side port with round-robin arbitration and bounded grant hold.
- Sits between the interconnect and the memory wrapper. The memory wrapper is unchanged.

Parameters:
- ADDR_W, 13: word address width, both sides.
- DATA_W, 32: data width.
- BE_W, 4: byteenable width (DATA_W/8).
- MAX_HOLD, 4: maximum consecutive accepted beats for one master while the other master waits. Legal range 1..15.

Ports:
- clk, in, 1: sole clock.
- reset_n, in, 1: synchronous, active-low reset.
- m0_address, in, ADDR_W: master 0 word address.
- m0_byteenable, in, BE_W: master 0 byte enables.
- m0_read, in, 1: master 0 read request.
- m0_write, in, 1: master 0 write request.
- m0_writedata, in, DATA_W: master 0 write data.
- m0_waitrequest, out, 1: master 0 stall.
- m0_readdata, out, DATA_W: master 0 read data.
- m0_readdatavalid, out, 1: master 0 read data valid.
- m1_*: same eight signals and widths for master 1.
- mem_address, out, ADDR_W: to RAM address.
- mem_byteenable, out, BE_W: to RAM byteenable.
- mem_chipselect, out, 1: to RAM chipselect.
- mem_write, out, 1: to RAM write.
- mem_writedata, out, DATA_W: to RAM writedata.
- mem_clken, out, 1: to RAM clken. Constant 1 when reset_n is high.
- mem_readdata, in, DATA_W: from RAM readdata.

Behaviour:
- Request and grant:
  - reqN = mN_read | mN_write. If both are asserted, the beat is a write.
  - At most one grant per cycle. grantN is combinational from the requests and the registered state.
  - mN_waitrequest = ~grantN. It is high while idle (Avalon-legal) and high for both masters while reset_n is low.
  - A beat is accepted on a clk edge where grantN is high.
- Registered state: last (1 bit, last granted master, reset 1 so m0 wins first) and hold_cnt (4 bits, reset 0).
- Grant rules, evaluated each cycle:
  - Only one master requesting: it is granted.
  - Both requesting and hold_cnt < MAX_HOLD: last is granted again.
  - Both requesting and hold_cnt == MAX_HOLD: the other master is granted.
  - Neither requesting: no grant; mem_chipselect = 0.
- Counter update on each accepted beat:
  - Same master as last: hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - Different master: last = N and hold_cnt = 1.
  - hold_cnt is unchanged on idle cycles.
- Memory side, combinational mux from the granted master:
  - mem_address, mem_byteenable and mem_writedata pass through from the granted master. They are don't-care when nothing is granted.
  - mem_chipselect = grant0 | grant1.
  - mem_write = granted master's write.
  - mem_clken = reset_n.
- Read return:
  - rd_pendN register is set on the edge that accepts a read from mN. It is cleared otherwise.
  - mN_readdatavalid = rd_pendN.
  - mN_readdata = mem_readdata for both ports. Only the valid flag differs.
  - Latency: read accepted at edge T, data valid in the cycle after T. Back-to-back reads give one datum per cycle.
- Writes: complete at the accepting edge. No readdatavalid is produced.
- Read-after-write, same address, consecutive beats: the read returns the new data, because the RAM is single-port and sequential.
- Reset (reset_n low at an edge):
  - last = 1, hold_cnt = 0, rd_pend0 = rd_pend1 = 0.
  - While reset_n is low: grants forced 0, waitrequests = 1, chipselect = 0, clken = 0.
  - Reset mid-transaction: a pending readdatavalid is dropped. A beat presented in the same cycle as reset is not accepted.
- No internal buffering. A master must hold its signals stable while waitrequest is high (Avalon rule).

Test Plan:
- Reset then single read: write 0xDEADBEEF to addr 0x010 via m0, then m0 read 0x010. Expect the read accepted with no wait. m0_readdatavalid = 1 exactly one cycle later with m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte enables: m1 writes 0x11223344 with be = 4'b0101 over existing 0x00000000. A subsequent read returns 0x00220044.
- Contention, MAX_HOLD = 4: m0 and m1 continuously request reads from cycle 0. Grant sequence is m0 x4, m1 x4, m0 x4. Each master's waitrequest is high only in the other master's windows.
- Alternating: m0 requests in even cycles only and m1 in odd cycles only. Every request is granted immediately with zero wait states.
- Read-after-write: m0 writes 0xA5A5A5A5 to 0x1FFF, next cycle m1 reads 0x1FFF. m1_readdata = 0xA5A5A5A5 with valid.
- Reset mid-read: m0 read accepted at edge T, reset_n low in the following cycle. m0_readdatavalid = 0 after the reset edge and both waitrequests are 1. After release, the first simultaneous requests grant m0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//   Two-master Avalon-MM arbiter in front of a single-port on-chip RAM
//   (altsyncram SINGLE_PORT, unregistered q, so read latency is 1 cycle).
//   Round-robin between m0 and m1. A master may hold the RAM for at most
//   MAX_HOLD consecutive beats while the other master is waiting.
//
// Ports
//   clk, reset_n        : sole clock, synchronous active-low reset
//   mN_address          : word address from master N (N = 0, 1)
//   mN_byteenable       : byte enables from master N
//   mN_read, mN_write   : request strobes (both high = write)
//   mN_writedata        : write data from master N
//   mN_waitrequest      : stall back to master N (high whenever not granted)
//   mN_readdata         : RAM read data, shared by both ports
//   mN_readdatavalid    : read data valid for master N, one cycle after accept
//   mem_*               : RAM-side address/byteenable/chipselect/write/
//                         writedata/clken outputs and readdata input
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  // Saturating increment of the hold counter at HOLD_MAX.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= HOLD_MAX) return HOLD_MAX;
    return v + 4'd1;
  endfunction

  logic       last;      // last granted master (1 = m1)
  logic [3:0] hold_cnt;  // consecutive beats accepted for 'last'
  logic       rd_pend0;
  logic       rd_pend1;

  logic req0, req1;
  logic grant0, grant1;
  logic pick1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // hold_cnt == 0 only straight out of reset: there is no history yet, so
  // the master opposite to 'last' (m0) gets the first contended grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    pick1  = last;
    if (reset_n) begin
      if (req0 && !req1) begin
        grant0 = 1'b1;
      end else if (req1 && !req0) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        if ((hold_cnt == 4'd0) || (hold_cnt >= HOLD_MAX)) pick1 = ~last;
        else                                             pick1 = last;
        grant1 = pick1;
        grant0 = ~pick1;
      end
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  // Memory-side mux: address/data are don't-care when nothing is granted.
  assign mem_address    = grant1 ? m1_address    : m0_address;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = grant0 | grant1;
  assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_clken      = reset_n;

  // Accept edge -> read-return cycle. A read beat with write also high is a
  // write, so it never raises a pending read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last     <= 1'b1;
      hold_cnt <= 4'd0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      rd_pend0 <= grant0 & m0_read & ~m0_write;
      rd_pend1 <= grant1 & m1_read & ~m1_write;
      if (grant0 || grant1) begin
        if (grant1 == last) begin
          hold_cnt <= sat_inc(hold_cnt);
        end else begin
          last     <= grant1;
          hold_cnt <= 4'd1;
        end
      end
    end
  end

  assign m0_readdatavalid = rd_pend0;
  assign m1_readdatavalid = rd_pend1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .BE_W(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered address, unregistered q.
  logic [31:0] ram [0:8191];
  logic [12:0] addr_q;
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    addr_q = 13'h0;
  end
  always @(posedge clk) begin
    if (mem_clken) begin
      addr_q <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[addr_q];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;
  bit mon_skip = 1'b0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever a port presents data.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_skip) begin
      if (q0.size() > 0 && q0[0].c < cyc) begin
        e = q0.pop_front();
        chk("rdv0_missing", 32'(m0_readdatavalid), 32'd1);
      end
      if (q1.size() > 0 && q1[0].c < cyc) begin
        e = q1.pop_front();
        chk("rdv1_missing", 32'(m1_readdatavalid), 32'd1);
      end
      if (m0_readdatavalid) begin
        if (q0.size() == 0) chk("rdv0_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("rd0_data", m0_readdata, e.d);
          chk("rd0_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (m1_readdatavalid) begin
        if (q1.size() == 0) chk("rdv1_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rd1_data", m1_readdata, e.d);
          chk("rd1_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  // One cycle: check the expected grant, record expected read data, advance.
  task automatic beat(input string nm, input bit eg0, input bit eg1,
                      input logic [31:0] ed0, input logic [31:0] ed1);
    @(negedge clk);
    chk({nm, "_wait0"}, 32'(m0_waitrequest), 32'(!eg0));
    chk({nm, "_wait1"}, 32'(m1_waitrequest), 32'(!eg1));
    chk({nm, "_cs"}, 32'(mem_chipselect), 32'(eg0 | eg1));
    if (eg0) begin
      chk({nm, "_addr"}, 32'(mem_address), 32'(m0_address));
      chk({nm, "_we"}, 32'(mem_write), 32'(m0_write));
      if (m0_read && !m0_write) q0.push_back('{d: ed0, c: cyc + 1});
    end
    if (eg1) begin
      chk({nm, "_addr"}, 32'(mem_address), 32'(m1_address));
      chk({nm, "_we"}, 32'(mem_write), 32'(m1_write));
      if (m1_read && !m1_write) q1.push_back('{d: ed1, c: cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string nm);
    @(negedge clk);
    chk({nm, "_wait0"}, 32'(m0_waitrequest), 32'd1);
    chk({nm, "_wait1"}, 32'(m1_waitrequest), 32'd1);
    chk({nm, "_cs"}, 32'(mem_chipselect), 32'd0);
    chk({nm, "_clken"}, 32'(mem_clken), 32'd0);
    chk({nm, "_rdv0"}, 32'(m0_readdatavalid), 32'd0);
    chk({nm, "_rdv1"}, 32'(m1_readdatavalid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 0;
    m1_address = 0; m1_byteenable = 4'hF; m1_writedata = 0;
    idle();
    m0_read = 1;                          // requests must be ignored in reset
    check_reset("rst_a");
    check_reset("rst_b");
    idle();
    reset_n = 1;

    // Write then read via m0
    m0_write = 1; m0_address = 13'h010; m0_writedata = 32'hDEADBEEF;
    beat("w0", 1, 0, 0, 0);
    m0_write = 0; m0_read = 1;
    beat("r0", 1, 0, 32'hDEADBEEF, 0);
    idle();
    @(negedge clk);
    chk("r0_valid", 32'(m0_readdatavalid), 32'd1);
    chk("r0_m1_valid", 32'(m1_readdatavalid), 32'd0);
    @(posedge clk); #1;

    // Byte-enabled write via m1 over zero
    m1_write = 1; m1_address = 13'h030; m1_writedata = 32'h11223344; m1_byteenable = 4'b0101;
    beat("w1_be", 0, 1, 0, 0);
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    beat("r1_be", 0, 1, 0, 32'h00220044);
    idle();
    beat("idle1", 0, 0, 0, 0);

    // Contention straight after reset
    reset_n = 0;
    check_reset("rst_c");
    reset_n = 1;
    m0_read = 1; m0_address = 13'h010;
    m1_read = 1; m1_address = 13'h030;
    for (int i = 0; i < 12; i++) begin
      bit g0;
      g0 = (i < 4) || (i >= 8);
      beat("cont", g0, !g0, 32'hDEADBEEF, 32'h00220044);
    end
    idle();
    beat("idle2", 0, 0, 0, 0);

    // Alternating single requests: zero wait states
    for (int i = 0; i < 8; i++) begin
      m0_read = (i % 2 == 0);
      m1_read = (i % 2 == 1);
      beat("alt", (i % 2 == 0), (i % 2 == 1), 32'hDEADBEEF, 32'h00220044);
    end
    idle();
    beat("idle3", 0, 0, 0, 0);

    // Read-after-write across masters, top address
    m0_write = 1; m0_address = 13'h1FFF; m0_writedata = 32'hA5A5A5A5;
    beat("raw_w", 1, 0, 0, 0);
    m0_write = 0; m1_read = 1; m1_address = 13'h1FFF;
    beat("raw_r", 0, 1, 0, 32'hA5A5A5A5);
    idle();
    beat("idle4", 0, 0, 0, 0);

    // Reset mid-read; a write presented during reset must not land
    m0_read = 1; m0_address = 13'h010;
    @(negedge clk);
    chk("rm_grant0", 32'(m0_waitrequest), 32'd0);
    @(posedge clk); #1;
    mon_skip = 1;
    reset_n = 0;
    m0_read = 0;
    m1_write = 1; m1_address = 13'h020; m1_writedata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rm_wait1", 32'(m1_waitrequest), 32'd1);
    chk("rm_cs", 32'(mem_chipselect), 32'd0);
    @(posedge clk); #1;
    check_reset("rm_after");
    m1_write = 0;
    reset_n = 1;
    mon_skip = 0;
    m0_read = 1; m0_address = 13'h010;
    m1_read = 1; m1_address = 13'h030;
    beat("post_both", 1, 0, 32'hDEADBEEF, 0);
    m0_read = 0;
    beat("post_m1", 0, 1, 0, 32'h00220044);
    m1_read = 0; m0_read = 1; m0_address = 13'h020;
    beat("rst_wr_dropped", 1, 0, 32'h0, 0);
    idle();
    beat("idle5", 0, 0, 0, 0);
    beat("idle6", 0, 0, 0, 0);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
